// File: rtl/systolic_mac_array_if.sv
// systolic_mac_array_if: weight, feature and result handshake bundle for systolic_mac_array.
// slave is the array side, master is the feature-buffer / activation side.
interface systolic_mac_array_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int ROWS   = 3,
  parameter int COLS   = 3
);
  logic                    w_valid_in;
  logic                    w_ready_out;
  logic [COLS*DATA_W-1:0]  w_data_in;
  logic                    f_valid_in;
  logic                    f_ready_out;
  logic [ROWS*DATA_W-1:0]  f_data_in;
  logic                    reload_in;
  logic                    out_valid_out;
  logic                    out_ready_in;
  logic [COLS*ACC_W-1:0]   out_data_out;
  logic [1:0]              state_out;

  modport slave (
    input  w_valid_in, w_data_in, f_valid_in, f_data_in, reload_in, out_ready_in,
    output w_ready_out, f_ready_out, out_valid_out, out_data_out, state_out
  );

  modport master (
    output w_valid_in, w_data_in, f_valid_in, f_data_in, reload_in, out_ready_in,
    input  w_ready_out, f_ready_out, out_valid_out, out_data_out, state_out
  );
endinterface

// File: rtl/systolic_mac_array.sv
// systolic_mac_array: weight-stationary ROWS x COLS systolic MAC array with load/run/drain control.
// Optional macro SYSTOLIC_SAT_EN: every PE accumulation saturates instead of wrapping.
module systolic_mac_array #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int ROWS   = 3,
  parameter int COLS   = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  systolic_mac_array_if.slave  bus
);
  localparam int DEPTH = ROWS + COLS;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_w [ROWS][COLS];
  logic [DEPTH-1:0]      r_vld;
  logic                  r_out_vld;
  logic [COLS*ACC_W-1:0] r_out;

  logic                  w_stall, w_en, w_w_acc, w_f_acc;
  logic [DATA_W-1:0]     w_x  [ROWS][COLS];
  logic [ACC_W-1:0]      w_ps [ROWS][COLS];
  logic [ACC_W-1:0]      w_col [COLS];

  // One global enable freezes the whole datapath while a result waits downstream.
  assign w_stall = r_out_vld & ~bus.out_ready_in;
  assign w_en    = ~w_stall;
  assign w_w_acc = bus.w_valid_in & (r_state == S_LOAD);
  assign w_f_acc = bus.f_valid_in & (r_state == S_RUN) & w_en;

  assign bus.w_ready_out   = (r_state == S_LOAD);
  assign bus.f_ready_out   = (r_state == S_RUN) & w_en;
  assign bus.out_valid_out = r_out_vld;
  assign bus.out_data_out  = r_out;
  assign bus.state_out     = r_state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_LOAD: if (bus.w_valid_in) begin
          if (r_cnt == CNT_W'(ROWS-1)) begin
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN:   if (bus.reload_in) r_state <= S_DRAIN;
        S_DRAIN: if ((r_vld == '0) && !r_out_vld) r_state <= S_LOAD;
        default: r_state <= S_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          r_w[r][c] <= '0;
    end else if (w_w_acc) begin
      for (int unsigned r = 0; r < ROWS; r++)
        if (r_cnt == CNT_W'(r))
          for (int unsigned c = 0; c < COLS; c++)
            r_w[r][c] <= bus.w_data_in[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld     <= '0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else if (w_en) begin
      r_vld     <= {r_vld[DEPTH-2:0], w_f_acc};
      r_out_vld <= r_vld[DEPTH-1];
      for (int unsigned c = 0; c < COLS; c++)
        r_out[c*ACC_W +: ACC_W] <= w_col[c];
    end
  end

  // Stage 0 captures the feature lane; row i adds i more stages of skew.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    logic [DATA_W-1:0] r_d [i+1];
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        for (int unsigned k = 0; k <= i; k++) r_d[k] <= '0;
      end else if (w_en) begin
        r_d[0] <= bus.f_data_in[i*DATA_W +: DATA_W];
        for (int unsigned k = 1; k <= i; k++) r_d[k] <= r_d[k-1];
      end
    end
    assign w_x[i][0] = r_d[i];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic               [ACC_W-1:0]    r_ps;
      logic               [ACC_W-1:0]    w_next;
      logic signed        [2*DATA_W-1:0] w_prod;
      logic signed        [ACC_W-1:0]    w_prod_ext;
      logic signed        [ACC_W-1:0]    w_ps_in;

      assign w_prod     = $signed(r_w[i][j]) * $signed(w_x[i][j]);
      assign w_prod_ext = ACC_W'(w_prod);

      if (i == 0) begin : g_top
        assign w_ps_in = '0;
      end else begin : g_chain
        assign w_ps_in = $signed(w_ps[i-1][j]);
      end

`ifdef SYSTOLIC_SAT_EN
      logic [ACC_W:0] w_sum;
      assign w_sum = {w_ps_in[ACC_W-1], w_ps_in} + {w_prod_ext[ACC_W-1], w_prod_ext};
      always_comb begin
        w_next = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1])
          w_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`else
      assign w_next = w_ps_in + w_prod_ext;
`endif

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)    r_ps <= '0;
        else if (w_en) r_ps <= w_next;
      end
      assign w_ps[i][j] = r_ps;

      if (j + 1 < COLS) begin : g_fwd
        logic [DATA_W-1:0] r_fx;
        always_ff @(posedge clk_in or posedge rst_in) begin
          if (rst_in)    r_fx <= '0;
          else if (w_en) r_fx <= w_x[i][j];
        end
        assign w_x[i][j+1] = r_fx;
      end
    end
  end

  // Earlier columns finish sooner; delay them so every lane lands together.
  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    localparam int DLY = COLS - 1 - j;
    if (DLY == 0) begin : g_pass
      assign w_col[j] = w_ps[ROWS-1][j];
    end else begin : g_dly
      logic [ACC_W-1:0] r_q [DLY];
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          for (int unsigned k = 0; k < DLY; k++) r_q[k] <= '0;
        end else if (w_en) begin
          r_q[0] <= w_ps[ROWS-1][j];
          for (int unsigned k = 1; k < DLY; k++) r_q[k] <= r_q[k-1];
        end
      end
      assign w_col[j] = r_q[DLY-1];
    end
  end
endmodule

// File: tb/tb_systolic_mac_array.sv
// tb_systolic_mac_array: directed checks of a 3x3 array at ACC_W=20 plus an ACC_W=16 twin
// driven with identical stimulus for the overflow case.
module tb_systolic_mac_array;
  logic        clk;
  logic        rst;
  logic        w_valid, f_valid, reload, out_ready;
  logic [23:0] w_data, f_data;
  int          n_vec = 0;
  int          n_err = 0;
  logic        flag;

  systolic_mac_array_if #(.DATA_W(8), .ACC_W(20), .ROWS(3), .COLS(3)) bus20 ();
  systolic_mac_array_if #(.DATA_W(8), .ACC_W(16), .ROWS(3), .COLS(3)) bus16 ();

  systolic_mac_array #(.DATA_W(8), .ACC_W(20), .ROWS(3), .COLS(3)) u_dut20 (
    .clk_in(clk), .rst_in(rst), .bus(bus20));
  systolic_mac_array #(.DATA_W(8), .ACC_W(16), .ROWS(3), .COLS(3)) u_dut16 (
    .clk_in(clk), .rst_in(rst), .bus(bus16));

  assign bus20.w_valid_in   = w_valid;
  assign bus20.w_data_in    = w_data;
  assign bus20.f_valid_in   = f_valid;
  assign bus20.f_data_in    = f_data;
  assign bus20.reload_in    = reload;
  assign bus20.out_ready_in = out_ready;
  assign bus16.w_valid_in   = w_valid;
  assign bus16.w_data_in    = w_data;
  assign bus16.f_valid_in   = f_valid;
  assign bus16.f_data_in    = f_data;
  assign bus16.reload_in    = reload;
  assign bus16.out_ready_in = out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] pack3(input int a0, input int a1, input int a2);
    logic [7:0] b0, b1, b2;
    b0 = 8'(a0);
    b1 = 8'(a1);
    b2 = 8'(a2);
    return {b2, b1, b0};
  endfunction

  function automatic logic signed [63:0] lane20(input int j);
    logic signed [19:0] v;
    v = bus20.out_data_out[j*20 +: 20];
    return v;
  endfunction

  function automatic logic signed [63:0] lane16(input int j);
    logic signed [15:0] v;
    v = bus16.out_data_out[j*16 +: 16];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_rows(input string tag, input logic [23:0] r0, input logic [23:0] r1,
                           input logic [23:0] r2);
    w_valid = 1'b1;
    w_data  = r0;
    tick();
    check({tag, "_beat1_state"}, bus20.state_out, 0);
    w_data = r1;
    tick();
    check({tag, "_beat2_state"}, bus20.state_out, 0);
    w_data = r2;
    tick();
    w_valid = 1'b0;
    check({tag, "_run_state"}, bus20.state_out, 1);
    check({tag, "_w_ready"}, bus20.w_ready_out, 0);
  endtask

  task automatic send_expect(input string tag, input logic [23:0] x, input int e0, input int e1,
                             input int e2);
    logic early;
    f_valid = 1'b1;
    f_data  = x;
    tick();
    f_valid = 1'b0;
    early = 1'b0;
    for (int k = 1; k < 6; k++) begin
      tick();
      if (bus20.out_valid_out !== 1'b0) early = 1'b1;
    end
    check({tag, "_early"}, early, 0);
    tick();
    check({tag, "_valid"}, bus20.out_valid_out, 1);
    check({tag, "_lane0"}, lane20(0), e0);
    check({tag, "_lane1"}, lane20(1), e1);
    check({tag, "_lane2"}, lane20(2), e2);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check({tag, "_drain"}, bus20.state_out, 2);
    for (int k = 0; k < 20; k++) begin
      if (bus20.state_out == 2'd0) break;
      tick();
    end
    check({tag, "_load"}, bus20.state_out, 0);
  endtask

  initial begin
    rst = 1'b1; w_valid = 1'b0; f_valid = 1'b0; reload = 1'b0; out_ready = 1'b1;
    w_data = '0; f_data = '0;
    tick();
    tick();
    check("rst_state", bus20.state_out, 0);
    check("rst_w_ready", bus20.w_ready_out, 1);
    check("rst_f_ready", bus20.f_ready_out, 0);
    check("rst_out_valid", bus20.out_valid_out, 0);
    check("rst_out_data", bus20.out_data_out, 0);
    rst = 1'b0;
    tick();

    // Identity weights
    load_rows("ident", pack3(1, 0, 0), pack3(0, 1, 0), pack3(0, 0, 1));
    check("ident_f_ready", bus20.f_ready_out, 1);
    send_expect("ident", pack3(1, 2, 3), 1, 2, 3);
    tick();
    check("ident_consumed", bus20.out_valid_out, 0);

    // Throughput with all weights 2
    do_reload("rl1");
    load_rows("w2", pack3(2, 2, 2), pack3(2, 2, 2), pack3(2, 2, 2));
    f_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      f_data = pack3(k, k, k);
      tick();
    end
    f_valid = 1'b0;
    tick();
    tick();
    check("tp_early", bus20.out_valid_out, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("tp_valid", bus20.out_valid_out, 1);
      check("tp_lane0", lane20(0), 6 * k);
      check("tp_lane2", lane20(2), 6 * k);
    end
    tick();
    check("tp_idle", bus20.out_valid_out, 0);

    // Backpressure while 12 is presented
    f_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      f_data = pack3(k, k, k);
      tick();
    end
    f_valid = 1'b0;
    tick();
    tick();
    tick();
    check("bp_first", lane20(0), 6);
    tick();
    check("bp_12", lane20(1), 12);
    out_ready = 1'b0;
    #1;
    check("bp_f_ready", bus20.f_ready_out, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_valid", bus20.out_valid_out, 1);
      check("bp_hold_data", lane20(1), 12);
    end
    out_ready = 1'b1;
    tick();
    check("bp_18", lane20(1), 18);
    tick();
    check("bp_24", lane20(1), 24);
    tick();
    check("bp_idle", bus20.out_valid_out, 0);

    // Reload in the same cycle as a feature accept
    f_valid = 1'b1;
    f_data  = pack3(1, 1, 1);
    reload  = 1'b1;
    tick();
    f_valid = 1'b0;
    reload  = 1'b0;
    check("rl_drain", bus20.state_out, 2);
    check("rl_f_ready", bus20.f_ready_out, 0);
    check("rl_w_ready", bus20.w_ready_out, 0);
    flag = 1'b0;
    for (int k = 1; k < 6; k++) begin
      tick();
      if (bus20.out_valid_out !== 1'b0 || bus20.state_out !== 2'd2) flag = 1'b1;
    end
    check("rl_wait", flag, 0);
    tick();
    check("rl_valid", bus20.out_valid_out, 1);
    check("rl_data", lane20(0), 6);
    check("rl_still_drain", bus20.state_out, 2);
    tick();
    check("rl_left", bus20.out_valid_out, 0);
    check("rl_drain_hold", bus20.state_out, 2);
    tick();
    check("rl_load", bus20.state_out, 0);
    load_rows("w3", pack3(3, 3, 3), pack3(3, 3, 3), pack3(3, 3, 3));
    send_expect("w3", pack3(1, 1, 1), 9, 9, 9);
    tick();

    // Signed overflow: 3 * (-128 * -128) = 49152
    do_reload("rl2");
    load_rows("wneg", pack3(-128, -128, -128), pack3(-128, -128, -128), pack3(-128, -128, -128));
    send_expect("ovf20", pack3(-128, -128, -128), 49152, 49152, 49152);
    check("ovf16_valid", bus16.out_valid_out, 1);
`ifdef SYSTOLIC_SAT_EN
    check("ovf16_lane0", lane16(0), 32767);
    check("ovf16_lane2", lane16(2), 32767);
`else
    check("ovf16_lane0", lane16(0), -16384);
    check("ovf16_lane2", lane16(2), -16384);
`endif
    tick();

    // Reset two cycles after an accept
    f_valid = 1'b1;
    f_data  = pack3(1, 1, 1);
    tick();
    f_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mrst_state", bus20.state_out, 0);
    check("mrst_w_ready", bus20.w_ready_out, 1);
    check("mrst_f_ready", bus20.f_ready_out, 0);
    tick();
    rst = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus20.out_valid_out !== 1'b0) flag = 1'b1;
    end
    check("mrst_no_output", flag, 0);
    check("mrst_state_after", bus20.state_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
